// File: rtl/instruction_loader.sv
// Assembles big-endian instruction words from a UART byte stream and writes
// them into the fetch-stage program memory, one session per i_start.
module instruction_loader #(
  parameter int unsigned ARQUITECTURE_BITS = 32,
  parameter int unsigned BYTE_BITS         = 8,
  parameter int unsigned MEM_SIZE_IN_WORDS = 40,
  localparam int unsigned WC_W             = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [BYTE_BITS-1:0]         i_rx_data,
  input  logic                         i_rx_valid,
  input  logic                         i_full_mem,
  output logic [ARQUITECTURE_BITS-1:0] o_instruction,
  output logic                         o_write_mem,
  output logic                         o_clear_mem,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [WC_W-1:0]              o_word_count
);

  localparam int unsigned BPW  = ARQUITECTURE_BITS / BYTE_BITS;
  localparam int unsigned BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RECV  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [BC_W-1:0]                bcnt_q, bcnt_d;
  logic [ARQUITECTURE_BITS-1:0]   asm_q, asm_d;
  logic [ARQUITECTURE_BITS-1:0]   instr_q, instr_d;
  logic [WC_W-1:0]                wc_q, wc_d;
  logic                           write_q, write_d;
  logic                           clear_q, clear_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;
  logic [ARQUITECTURE_BITS-1:0]   word_c;

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      asm_q   <= '0;
      instr_q <= '0;
      wc_q    <= '0;
      write_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      instr_q <= instr_d;
      wc_q    <= wc_d;
      write_q <= write_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state, assembler and strobe decode; strobes land one cycle later
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    instr_d = instr_q;
    wc_d    = wc_q;
    write_d = 1'b0;
    clear_d = 1'b0;
    done_d  = 1'b0;
    error_d = error_q;
    word_c  = {asm_q[ARQUITECTURE_BITS-BYTE_BITS-1:0], i_rx_data};

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_CLEAR;
          clear_d = 1'b1;
          error_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        bcnt_d  = '0;
        wc_d    = '0;
        asm_d   = '0;
        state_d = ST_RECV;
      end
      ST_RECV: begin
        if (i_rx_valid) begin
          asm_d = word_c;
          if (bcnt_q == BC_W'(BPW - 1)) begin
            bcnt_d = '0;
            // Overflow wins over the halt word: nothing is written
            if (i_full_mem || (wc_q == WC_W'(MEM_SIZE_IN_WORDS))) begin
              state_d = ST_ERROR;
              error_d = 1'b1;
            end else begin
              write_d = 1'b1;
              instr_d = word_c;
              wc_d    = wc_q + 1'b1;
              if (&word_c) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_RECV);
  end

  assign o_instruction = instr_q;
  assign o_write_mem   = write_q;
  assign o_clear_mem   = clear_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_word_count  = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected words are queued as
// bytes are driven and popped on every observed write strobe.
module tb_instruction_loader;

  localparam int unsigned AW   = 32;
  localparam int unsigned BW   = 8;
  localparam int unsigned MEMW = 40;
  localparam int unsigned WCW  = $clog2(MEMW + 1);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [BW-1:0]  rx_data;
  logic           rx_valid;
  logic           full_mem;
  logic [AW-1:0]  instruction;
  logic           write_mem;
  logic           clear_mem;
  logic           busy;
  logic           done;
  logic           error;
  logic [WCW-1:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_clr    = 0;
  int n_done   = 0;
  logic prev_wr = 1'b0;
  logic [AW-1:0] exp_q[$];

  instruction_loader #(
    .ARQUITECTURE_BITS(AW),
    .BYTE_BITS(BW),
    .MEM_SIZE_IN_WORDS(MEMW)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_start(start),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_full_mem(full_mem),
    .o_instruction(instruction),
    .o_write_mem(write_mem),
    .o_clear_mem(clear_mem),
    .o_busy(busy),
    .o_done(done),
    .o_error(error),
    .o_word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Write monitor: pops the scoreboard and checks single-cycle strobes
  always @(negedge clk) begin
    if (write_mem) begin
      n_wr++;
      chk("wr_pulse_width", 32'(prev_wr), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else chk("write_data", instruction, exp_q.pop_front());
    end
    if (clear_mem) n_clr++;
    if (done) n_done++;
    prev_wr = write_mem;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [BW-1:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] w, input int gap, input bit expect_wr);
    if (expect_wr) exp_q.push_back(w);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8]);
      if (k < 3) repeat (gap) tick();
    end
  endtask

  // Leaves the caller in the CLEAR cycle
  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int w0, d0, c0;
    rst_n = 1'b0; start = 1'b0; rx_data = '0; rx_valid = 1'b0; full_mem = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_strobes", {27'd0, write_mem, clear_mem, busy, done, error}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Basic session: one word with gaps, then halt
    start_session();
    @(negedge clk);
    chk("t1_clear", 32'(clear_mem), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_clear_one_cycle", 32'(clear_mem), 32'd0);
    tick();
    send_word(32'h12345678, 1, 1'b1);
    @(negedge clk);
    chk("t1_wr1", 32'(write_mem), 32'd1);
    chk("t1_wc1", 32'(word_count), 32'd1);
    tick();
    send_word(32'hFFFFFFFF, 2, 1'b1);
    @(negedge clk);
    chk("t1_halt_wr", 32'(write_mem), 32'd1);
    chk("t1_halt_done", 32'(done), 32'd1);
    chk("t1_halt_busy", 32'(busy), 32'd0);
    chk("t1_wc2", 32'(word_count), 32'd2);
    chk("t1_err", 32'(error), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    tick();

    // Back-to-back bytes: every write cycle also accepts a byte
    w0 = n_wr; d0 = n_done;
    start_session();
    tick();
    send_word(32'h01020304, 0, 1'b1);
    send_word(32'hA5B6C7D8, 0, 1'b1);
    send_word(32'h00000000, 0, 1'b1);
    send_word(32'hFFFFFFFF, 0, 1'b1);
    repeat (3) tick();
    chk("t2_writes", 32'(n_wr - w0), 32'd4);
    chk("t2_done", 32'(n_done - d0), 32'd1);
    chk("t2_wc", 32'(word_count), 32'd4);

    // Fill memory, then overflow on word 41
    w0 = n_wr;
    start_session();
    tick();
    for (int i = 0; i < MEMW; i++) send_word(32'(i) * 32'h01010101 + 32'h00000101, i % 2, 1'b1);
    @(negedge clk);
    chk("t3_wc40", 32'(word_count), 32'd40);
    tick();
    send_word(32'h5A5A5A5A, 0, 1'b0);
    @(negedge clk);
    chk("t3_ovf_nowrite", 32'(write_mem), 32'd0);
    chk("t3_ovf_err", 32'(error), 32'd1);
    chk("t3_ovf_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("t3_writes", 32'(n_wr - w0), 32'd40);
    chk("t3_err_sticky", 32'(error), 32'd1);
    chk("t3_wc_hold", 32'(word_count), 32'd40);
    start_session();
    @(negedge clk);
    chk("t3_restart_clear", 32'(clear_mem), 32'd1);
    chk("t3_restart_err", 32'(error), 32'd0);
    tick();

    // Memory full flag blocks the write
    full_mem = 1'b1;
    send_word(32'hAABBCCDD, 0, 1'b0);
    @(negedge clk);
    chk("t4_full_nowrite", 32'(write_mem), 32'd0);
    chk("t4_full_err", 32'(error), 32'd1);
    full_mem = 1'b0;
    repeat (3) tick();

    // Bytes in IDLE ignored; mid-session start ignored
    send_word(32'h11223344, 0, 1'b0);
    tick();
    chk("t5_idle_wc", 32'(word_count), 32'd0);
    start_session();
    tick();
    c0 = n_clr;
    exp_q.push_back(32'h55667788);
    send_byte(8'h55);
    send_byte(8'h66);
    start = 1'b1;
    send_byte(8'h77);
    start = 1'b0;
    send_byte(8'h88);
    @(negedge clk);
    chk("t5_wc", 32'(word_count), 32'd1);
    chk("t5_no_reclear", 32'(n_clr - c0), 32'd0);
    tick();

    // Asynchronous reset mid-word
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_instr", instruction, 32'd0);
    chk("t6_rst_wc", 32'(word_count), 32'd0);
    chk("t6_rst_strobes", {27'd0, write_mem, clear_mem, busy, done, error}, 32'd0);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    start_session();
    tick();
    send_word(32'hCAFEBABE, 0, 1'b1);
    send_word(32'hFFFFFFFF, 1, 1'b1);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_wc", 32'(word_count), 32'd2);
    repeat (3) tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
